// File: rtl/fba_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fba_pkg : shared constants, index type and address helper for the          |
// |           frame_buffer_arbiter frame-store manager.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fba_pkg;

  localparam int FBA_MAX_BUFFERS = 16;
  localparam int FBA_CNT_WIDTH   = 16;
  localparam int FBA_IDX_MAX_W   = $clog2(FBA_MAX_BUFFERS);

  typedef logic [FBA_IDX_MAX_W-1:0] fba_idx_t;

  // Computed at 64 bits; callers truncate to their address width for wrap-around.
  function automatic logic [63:0] fba_addr(input logic [63:0] base,
                                           input fba_idx_t    idx,
                                           input int          log2size);
    return base + (64'(idx) << log2size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fba_next_idx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fba_next_idx : picks the next write buffer, the first of cur+1..cur+3      |
// |                (mod NUM_BUFFERS) that is neither latest nor locked.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fba_next_idx #(
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_WIDTH   = $clog2(NUM_BUFFERS)
) (
  input  logic [IDX_WIDTH-1:0] cur_idx,
  input  logic [IDX_WIDTH-1:0] latest_idx,
  input  logic [IDX_WIDTH-1:0] lock_idx,
  input  logic                 lock_valid,
  output logic [IDX_WIDTH-1:0] next_idx
);

  localparam int                SUM_W = IDX_WIDTH + 2;
  localparam logic [SUM_W-1:0]  NUM_B = SUM_W'(NUM_BUFFERS);

  logic [2:0][IDX_WIDTH-1:0] cand;
  logic [2:0]                ok;

  // cur+k stays below 2*NUM_BUFFERS, so one conditional subtract is a full modulo.
  for (genvar k = 1; k <= 3; k++) begin : g_cand
    logic [SUM_W-1:0] sum;
    assign sum        = {2'b00, cur_idx} + SUM_W'(k);
    assign cand[k-1]  = (sum >= NUM_B) ? IDX_WIDTH'(sum - NUM_B) : sum[IDX_WIDTH-1:0];
    assign ok[k-1]    = (cand[k-1] != latest_idx) &&
                        !(lock_valid && (cand[k-1] == lock_idx));
  end

  always_comb begin
    next_idx = cand[0];
    if (ok[0])      next_idx = cand[0];
    else if (ok[1]) next_idx = cand[1];
    else if (ok[2]) next_idx = cand[2];
  end

endmodule
`default_nettype wire

// File: rtl/frame_buffer_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_buffer_arbiter : N-buffer tear-free frame-store manager between DDR  |
// |   frame writer and reader. Define FBA_STATS_EN for drop/repeat counters.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module frame_buffer_arbiter
  import fba_pkg::*;
#(
  parameter int NUM_BUFFERS      = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BUFFER_SIZE_LOG2 = 23,
  parameter int IDX_WIDTH        = $clog2(NUM_BUFFERS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic                  wr_finish,
  input  logic                  rd_start,
  input  logic                  rd_finish,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic [IDX_WIDTH-1:0]  wr_idx,
  output logic [IDX_WIDTH-1:0]  rd_idx,
  output logic                  rd_busy,
  output logic                  frame_valid
`ifdef FBA_STATS_EN
  ,
  output logic [FBA_CNT_WIDTH-1:0] drop_count,
  output logic [FBA_CNT_WIDTH-1:0] repeat_count
`endif
);

  logic [IDX_WIDTH-1:0] latest_idx;
  logic                 latest_read;

  logic                 any_valid;
  logic                 lock;
  logic [IDX_WIDTH-1:0] latest_idx_nxt;
  logic [IDX_WIDTH-1:0] rd_idx_nxt;
  logic                 rd_busy_nxt;
  logic                 latest_read_nxt;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic [IDX_WIDTH-1:0] wr_idx_nxt;

  // Release is applied before lock, and a lock in the same cycle as wr_finish
  // grabs the frame that just completed.
  always_comb begin
    any_valid       = frame_valid | wr_finish;
    lock            = rd_start & any_valid;
    latest_idx_nxt  = wr_finish ? wr_idx : latest_idx;
    rd_idx_nxt      = lock ? latest_idx_nxt : rd_idx;
    rd_busy_nxt     = lock | (rd_busy & ~rd_finish);
    latest_read_nxt = lock ? 1'b1 : (wr_finish ? 1'b0 : latest_read);
    wr_idx_nxt      = wr_finish ? cand_idx : wr_idx;
  end

  fba_next_idx #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_next_idx (
    .cur_idx    (wr_idx),
    .latest_idx (latest_idx_nxt),
    .lock_idx   (rd_idx_nxt),
    .lock_valid (rd_busy_nxt),
    .next_idx   (cand_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx      <= '0;
      rd_idx      <= '0;
      latest_idx  <= '0;
      latest_read <= 1'b0;
      rd_busy     <= 1'b0;
      frame_valid <= 1'b0;
      wr_address  <= '0;
      rd_address  <= '0;
    end else begin
      wr_idx      <= wr_idx_nxt;
      rd_idx      <= rd_idx_nxt;
      latest_idx  <= latest_idx_nxt;
      latest_read <= latest_read_nxt;
      rd_busy     <= rd_busy_nxt;
      frame_valid <= any_valid;
      wr_address  <= ADDR_WIDTH'(fba_addr(64'(base_address), fba_idx_t'(wr_idx_nxt),
                                          BUFFER_SIZE_LOG2));
      rd_address  <= ADDR_WIDTH'(fba_addr(64'(base_address), fba_idx_t'(rd_idx_nxt),
                                          BUFFER_SIZE_LOG2));
    end
  end

`ifdef FBA_STATS_EN
  logic drop_evt;
  logic repeat_evt;

  // A lock coinciding with wr_finish reads a fresh frame, so it is never a repeat.
  assign drop_evt   = wr_finish & frame_valid & ~latest_read;
  assign repeat_evt = lock & ~wr_finish & latest_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count   <= '0;
      repeat_count <= '0;
    end else begin
      if (drop_evt && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      if (repeat_evt && (repeat_count != '1))
        repeat_count <= repeat_count + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_n && rd_busy)
      assert (wr_idx != rd_idx);
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_buffer_arbiter : directed + random self-checking bench with an    |
// |   event-ordered reference model of the buffer-selection rules.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_frame_buffer_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int L2 = 23;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] base_address = 32'h8000_0000;
  logic          wr_finish = 1'b0;
  logic          rd_start  = 1'b0;
  logic          rd_finish = 1'b0;
  logic [AW-1:0] wr_address;
  logic [AW-1:0] rd_address;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          rd_busy;
  logic          frame_valid;
`ifdef FBA_STATS_EN
  logic [15:0]   drop_count;
  logic [15:0]   repeat_count;
`endif

  always #5 clk = ~clk;

  frame_buffer_arbiter #(
    .NUM_BUFFERS      (N),
    .ADDR_WIDTH       (AW),
    .BUFFER_SIZE_LOG2 (L2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .base_address (base_address),
    .wr_finish    (wr_finish),
    .rd_start     (rd_start),
    .rd_finish    (rd_finish),
    .wr_address   (wr_address),
    .rd_address   (rd_address),
    .wr_idx       (wr_idx),
    .rd_idx       (rd_idx),
    .rd_busy      (rd_busy),
    .frame_valid  (frame_valid)
`ifdef FBA_STATS_EN
    ,
    .drop_count   (drop_count),
    .repeat_count (repeat_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_wr, m_rd, m_latest, m_drop, m_rep;
  bit            m_busy, m_valid, m_lr;
  logic [AW-1:0] m_base;

  function automatic logic [AW-1:0] buf_addr(input logic [AW-1:0] b, input int idx);
    logic [63:0] full;
    full = 64'(b) + 64'(idx) * 64'(2 ** L2);
    return full[AW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_latest = 0; m_drop = 0; m_rep = 0;
    m_busy = 0; m_valid = 0; m_lr = 0;
  endtask

  // Events are applied in order: release, frame completion, lock, writer choice.
  task automatic model_edge(input bit wf, input bit rs, input bit rf);
    bit found;
    int cand;
    if (rf) m_busy = 0;
    if (wf) begin
      if (m_valid && !m_lr && m_drop < 65535) m_drop++;
      m_latest = m_wr;
      m_valid  = 1;
      m_lr     = 0;
    end
    if (rs && m_valid) begin
      if (m_lr && m_rep < 65535) m_rep++;
      m_rd   = m_latest;
      m_busy = 1;
      m_lr   = 1;
    end
    if (wf) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        cand = (m_wr + k) % N;
        if (!found && cand != m_latest && !(m_busy && cand == m_rd)) begin
          m_wr  = cand;
          found = 1;
        end
      end
    end
    m_base = base_address;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wr_idx"},      64'(wr_idx),      64'(m_wr));
    check({tag, ".rd_idx"},      64'(rd_idx),      64'(m_rd));
    check({tag, ".rd_busy"},     64'(rd_busy),     64'(m_busy));
    check({tag, ".frame_valid"}, 64'(frame_valid), 64'(m_valid));
    check({tag, ".wr_address"},  64'(wr_address),  64'(buf_addr(m_base, m_wr)));
    check({tag, ".rd_address"},  64'(rd_address),  64'(buf_addr(m_base, m_rd)));
    check({tag, ".invariant"},   64'(rd_busy && (wr_idx == rd_idx)), 64'(0));
`ifdef FBA_STATS_EN
    check({tag, ".drop_count"},   64'(drop_count),   64'(m_drop));
    check({tag, ".repeat_count"}, 64'(repeat_count), 64'(m_rep));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wr_idx"},      64'(wr_idx),      64'(0));
    check({tag, ".rd_idx"},      64'(rd_idx),      64'(0));
    check({tag, ".rd_busy"},     64'(rd_busy),     64'(0));
    check({tag, ".frame_valid"}, 64'(frame_valid), 64'(0));
    check({tag, ".wr_address"},  64'(wr_address),  64'(0));
    check({tag, ".rd_address"},  64'(rd_address),  64'(0));
`ifdef FBA_STATS_EN
    check({tag, ".drop_count"},   64'(drop_count),   64'(0));
    check({tag, ".repeat_count"}, 64'(repeat_count), 64'(0));
`endif
  endtask

  task automatic step(input bit wf, input bit rs, input bit rf, input string tag);
    @(negedge clk);
    wr_finish = wf; rd_start = rs; rd_finish = rf;
    @(posedge clk);
    model_edge(wf, rs, rf);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    wr_finish = 0; rd_start = 0; rd_finish = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit wf, rs, rf;
    model_reset();

    // Reset then idle
    base_address = 32'h8000_0000;
    apply_reset("reset");
    step(0, 0, 0, "idle");
    check("idle.wr_addr_base", 64'(wr_address), 64'h8000_0000);
    check("idle.rd_addr_base", 64'(rd_address), 64'h8000_0000);

    // Writer only: 1,2,0,1
    step(1, 0, 0, "wonly1");
    check("wonly1.idx",  64'(wr_idx), 64'd1);
    check("wonly1.addr", 64'(wr_address), 64'h8080_0000);
    step(1, 0, 0, "wonly2");
    check("wonly2.idx",  64'(wr_idx), 64'd2);
    check("wonly2.addr", 64'(wr_address), 64'h8100_0000);
    step(1, 0, 0, "wonly3");
    check("wonly3.idx",  64'(wr_idx), 64'd0);
    step(1, 0, 0, "wonly4");
    check("wonly4.idx",  64'(wr_idx), 64'd1);
`ifdef FBA_STATS_EN
    check("wonly4.drops", 64'(drop_count), 64'd3);
`endif

    // Writer skips the locked buffer
    apply_reset("reset2");
    step(1, 0, 0, "lock.wf");
    step(0, 1, 0, "lock.rs");
    check("lock.rd_idx",  64'(rd_idx), 64'd0);
    check("lock.rd_addr", 64'(rd_address), 64'h8000_0000);
    step(1, 0, 0, "lock.wf2");
    check("lock.wf2.idx", 64'(wr_idx), 64'd2);
    step(1, 0, 0, "lock.wf3");
    check("lock.wf3.idx", 64'(wr_idx), 64'd1);

    // Simultaneous wr_finish + rd_start
    apply_reset("reset3");
    step(1, 0, 0, "sim.pre");
    step(1, 1, 0, "sim");
    check("sim.rd_idx", 64'(rd_idx), 64'd1);
    check("sim.wr_idx", 64'(wr_idx), 64'd2);

    // rd_start before any frame, then repeat read
    apply_reset("reset4");
    step(0, 1, 0, "early.rs");
    check("early.busy", 64'(rd_busy), 64'd0);
    step(1, 0, 0, "rep.wf");
    step(0, 1, 0, "rep.rs1");
    step(0, 1, 0, "rep.rs2");
`ifdef FBA_STATS_EN
    check("rep.count", 64'(repeat_count), 64'd1);
`endif
    step(1, 0, 1, "rel.wf_rf");

    // Address wrap and asynchronous reset mid-lock
    apply_reset("reset5");
    base_address = 32'hFFC0_0000;
    step(1, 0, 0, "wrap1");
    step(1, 0, 0, "wrap2");
    check("wrap.idx",  64'(wr_idx), 64'd2);
    check("wrap.addr", 64'(wr_address), 64'h00C0_0000);
    step(0, 1, 0, "wrap.lock");
    @(negedge clk);
    wr_finish = 0; rd_start = 0; rd_finish = 0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_zero("async");
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic against the model
    base_address = 32'h8000_0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0)
        base_address = $urandom();
      wf = ($urandom_range(0, 9) < 4);
      rs = ($urandom_range(0, 9) < 3);
      rf = ($urandom_range(0, 9) < 3);
      step(wf, rs, rf, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    wr_finish = 0; rd_start = 0; rd_finish = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Parametrised N-buffer frame-store manager between the DDR frame writer and the DDR frame reader. Successor to the fixed 4-buffer round-robin address generator: adds reader lock/release handshakes and a tear-free buffer choice. The writer never targets the buffer being read or the newest complete frame, and the reader always gets the newest complete frame. Optionally counts dropped and repeated frames.

## Interface
- NUM_BUFFERS, 3: number of frame buffers, legal range 3..16.
- ADDR_WIDTH, 32: DDR byte-address width.
- BUFFER_SIZE_LOG2, 23: log2 of per-buffer byte stride (8 MB).
- IDX_WIDTH, $clog2(NUM_BUFFERS): buffer-index width (derived, not overridden).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- base_address  in  ADDR_WIDTH  byte address of buffer 0; quasi-static.
- wr_finish  in  1  one-cycle pulse: writer completed frame in current wr buffer.
- rd_start  in  1  one-cycle pulse: reader begins a frame; locks newest frame.
- rd_finish  in  1  one-cycle pulse: reader done; releases lock.
- wr_address  out  ADDR_WIDTH  base of buffer the writer must fill.
- rd_address  out  ADDR_WIDTH  base of buffer the reader must read.
- wr_idx  out  IDX_WIDTH  current write buffer index.
- rd_idx  out  IDX_WIDTH  current read buffer index.
- rd_busy  out  1  reader holds a lock.
- frame_valid  out  1  at least one frame completed since reset.
- drop_count  out  16  frames overwritten unread (only with FBA_STATS_EN).
- repeat_count  out  16  frames read twice or more (only with FBA_STATS_EN).

## Operation
- State: wr_idx, latest_idx, latest_read flag, rd_idx, rd_busy, frame_valid.
- wr_finish:
  - latest_idx <= wr_idx; frame_valid <= 1; latest_read <= 0.
  - wr_idx <= first of (wr_idx+1, +2, +3) mod NUM_BUFFERS that is neither the new latest_idx nor (rd_busy ? rd_idx : none).
  - N>=3 guarantees a candidate within three steps.
- rd_start with frame_valid=1: rd_idx <= latest_idx; rd_busy <= 1; latest_read <= 1.
- rd_start with frame_valid=0: ignored; rd_busy stays 0, rd_idx stays 0.
- rd_start while rd_busy=1: treated as implicit release plus new lock.
- rd_finish: rd_busy <= 0; rd_idx holds its value.
- Simultaneous events in one cycle:
  - wr_finish + rd_start: reader locks the just-finished buffer (old wr_idx). The writer's next choice excludes that buffer once, because it is both latest and locked.
  - rd_finish + rd_start: lock wins, same as rd_start alone.
  - wr_finish + rd_finish: the release is applied first, so the writer may choose the old rd_idx.
- Address arithmetic: address = base_address + (idx << BUFFER_SIZE_LOG2), truncated modulo 2^ADDR_WIDTH; no overflow flag.
- Invariant, checked by assertion: rd_busy implies wr_idx != rd_idx.

## Timing
- All state updates on the rising clk edge after the pulse cycle.
- wr_address and rd_address are registered from next-state indices and the current base_address: valid the cycle after the event, 1-cycle latency.
- Addresses recompute every cycle, so a base_address change appears one cycle later.
- Reset (asynchronous assert, synchronous deassert at source) sets every output to 0: wr_idx, rd_idx, latest_idx, rd_busy, frame_valid, both counters, and both addresses.
- From the first edge after deassertion, both addresses equal base_address.
- Reset mid-frame discards all locks and history; there is no recovery handshake.
- Pulses held longer than 1 cycle are interpreted as repeated events.

## Configuration
- FBA_STATS_EN defined:
  - drop_count increments when wr_finish replaces a latest frame with latest_read=0 and frame_valid=1.
  - repeat_count increments when rd_start locks a latest frame with latest_read=1.
  - Both counters saturate at 0xFFFF and reset to 0.
- FBA_STATS_EN undefined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Package fba_pkg holds:
  - FBA_MAX_BUFFERS = 16
  - FBA_CNT_WIDTH = 16
  - typedef fba_idx_t
  - function fba_addr(base, idx, log2size)
- Sub-module fba_next_idx: combinational candidate search taking current idx, excluded latest, excluded locked idx and lock-valid; returns the next write idx.
- Top level: registers, handshake decode, address registers, optional stats.

## Test plan
- Parameters for all scenarios: NUM_BUFFERS=3, log2 size 23, base 0x8000_0000.
- Reset then idle: all outputs 0; one cycle later wr_address = rd_address = 0x8000_0000, frame_valid=0.
- Writer-only, 4 wr_finish pulses with no reader: wr_idx sequence 1,2,0,1; wr_address 0x8080_0000 then 0x8100_0000; drop_count=3.
- wr_finish, then rd_start, then 2 wr_finish: rd_idx=0, rd_address 0x8000_0000; writer sequence 1→2→1 (skips locked 0); wr_idx never equals rd_idx.
- wr_finish + rd_start in the same cycle, with wr_idx=1 and rd_busy=0: rd_idx=1, latest=1, next wr_idx=2.
- rd_start before any frame: rd_busy stays 0; then 2 rd_start after one wr_finish gives repeat_count=1.
- base_address = 0xFFC0_0000 with idx 2: wr_address wraps to 0x00C0_0000; assert reset_n mid-lock and all state returns to 0 asynchronously.
